// File: rtl/alu_sync_driver.sv
// ---------------------------------------------------------------------------
// alu_sync_driver
//
// Initiator side of the registered-ALU interface. Commands from the decoder
// are queued in a small FIFO. Each command is then driven into the
// synchronous ALU for exactly one enabled cycle. The ALU's registered A/F
// outputs are captured and returned on a response port. Only one command is
// in flight at a time.
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid and ready are both 1.
//  - The producer holds valid and its payload steady until that edge.
//  - ready never depends on valid combinationally.
//  - On this block, cmd_ready = !full.
//  - rsp_valid/rsp_a/rsp_f stay stable until the response is taken.
//
// Ports
//  clk, reset                 clock; synchronous active-high reset
//  cmd_valid/ready            command handshake
//  cmd_op/x/y/write_a         command payload
//  rsp_valid/ready            response handshake
//  rsp_a, rsp_f               captured ALU A and F
//  alu_op/x/y/enable/write_a  registered drive into the ALU
//  alu_a, alu_f               registered ALU outputs
//  fifo_count                 commands queued but not yet issued
//  busy                       FSM not idle, or the queue is non-empty
//
// FSM sequence for one command:
//   IDLE/RESP --pop--> ISSUE (alu_enable=1) -> CAPTURE -> RESP
// ---------------------------------------------------------------------------
module alu_sync_driver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [4:0]                    cmd_op,
  input  logic [15:0]                   cmd_x,
  input  logic [15:0]                   cmd_y,
  input  logic                          cmd_write_a,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [15:0]                   rsp_a,
  output logic [7:0]                    rsp_f,
  output logic [4:0]                    alu_op,
  output logic [15:0]                   alu_x,
  output logic [15:0]                   alu_y,
  output logic                          alu_enable,
  output logic                          alu_write_a,
  input  logic [15:0]                   alu_a,
  input  logic [7:0]                    alu_f,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic        write_a;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          rsp_set;
  logic          rsp_clr;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // A pop in the same cycle does not make room for a push.
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign fifo_count = count;
  assign busy       = (state != IDLE) || !empty;

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rsp_set    = 1'b0;
    rsp_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        // The ALU registered this op's result on the ISSUE->CAPTURE edge.
        rsp_set    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_clr = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Queue storage. Nothing reads it until the pointers and count allow.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, x: cmd_x, y: cmd_y, write_a: cmd_write_a};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      alu_op      <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_enable  <= 1'b0;
      alu_write_a <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_a       <= '0;
      rsp_f       <= '0;
    end else begin
      state <= state_next;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Every pop enters ISSUE, so the enable pulse is exactly the pop strobe
      // delayed by one edge. The operand registers hold their value otherwise.
      alu_enable <= pop;
      if (pop) begin
        alu_op      <= mem[rd_ptr].op;
        alu_x       <= mem[rd_ptr].x;
        alu_y       <= mem[rd_ptr].y;
        alu_write_a <= mem[rd_ptr].write_a;
      end

      if (rsp_set) begin
        rsp_a     <= alu_a;
        rsp_f     <= alu_f;
        rsp_valid <= 1'b1;
      end else if (rsp_clr) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sync_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_sync_driver
//
// Drives alu_sync_driver against a small synchronous ALU model. Expected
// {rsp_a, rsp_f} values are pushed to exp_q when a command is accepted.
// Results come from an independent accumulator model. A negedge monitor pops
// exp_q and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_sync_driver;

  localparam int FIFO_DEPTH = 4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_op;
  logic [15:0]   cmd_x;
  logic [15:0]   cmd_y;
  logic          cmd_write_a;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_a;
  logic [7:0]    rsp_f;
  logic [4:0]    alu_op;
  logic [15:0]   alu_x;
  logic [15:0]   alu_y;
  logic          alu_enable;
  logic          alu_write_a;
  logic [15:0]   alu_a;
  logic [7:0]    alu_f;
  logic [CW-1:0] fifo_count;
  logic          busy;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [23:0]   exp_q[$];
  logic [15:0]   acc_model;
  logic [23:0]   alu_r;

  alu_sync_driver #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_write_a(cmd_write_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_f(rsp_f),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_enable(alu_enable),
    .alu_write_a(alu_write_a), .alu_a(alu_a), .alu_f(alu_f),
    .fifo_count(fifo_count), .busy(busy)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU behaviour: returns {a, f} ----------------
  // f = {zero, negative, carry, op}
  function automatic logic [23:0] alu_calc(input logic [4:0] op,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
    logic [16:0] s;
    case (op)
      5'd0:    s = {1'b0, x} + {1'b0, y};
      5'd1:    s = {1'b0, x} - {1'b0, y};
      5'd2:    s = {1'b0, x & y};
      5'd3:    s = {1'b0, x | y};
      5'd4:    s = {1'b0, x ^ y};
      default: s = {1'b0, x};
    endcase
    return {s[15:0], (s[15:0] == 16'h0), s[15], s[16], op};
  endfunction

  // Synchronous ALU model sharing the driver's reset.
  assign alu_r = alu_calc(alu_op, alu_x, alu_y);
  always @(posedge clk) begin
    if (reset) begin
      alu_a <= '0;
      alu_f <= '0;
    end else if (alu_enable) begin
      if (alu_write_a) alu_a <= alu_r[23:8];
      alu_f <= alu_r[7:0];
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_enable) begin
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL enable_while_pending: rsp_valid=%0b required 0", rsp_valid);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rsp: got a=%h f=%h with empty queue", rsp_a, rsp_f);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if ({rsp_a, rsp_f} !== e) begin
            n_bad++;
            $display("FAIL rsp_data: got a=%h f=%h required a=%h f=%h",
                     rsp_a, rsp_f, e[23:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic apply_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    acc_model = '0;
  endtask

  // Leaves cmd_valid high on return so consecutive calls push back-to-back.
  task automatic push_cmd(input logic [4:0] op, input logic [15:0] x,
                          input logic [15:0] y, input logic wa);
    logic        taken;
    logic [23:0] r;
    cmd_op      = op;
    cmd_x       = x;
    cmd_y       = y;
    cmd_write_a = wa;
    cmd_valid   = 1'b1;
    taken       = 1'b0;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clk);
      taken = cmd_ready;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!taken) begin
      n_bad++;
      $display("FAIL push_timeout: cmd_ready=%0b required 1 within 200 cycles", cmd_ready);
    end else begin
      r = alu_calc(op, x, y);
      exp_q.push_back(wa ? r : {acc_model, r[7:0]});
      if (wa) acc_model = r[23:8];
    end
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    cmd_valid = 1'b0;
    done      = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && !busy;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b required 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic wait_rsp_valid(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL rsp_valid_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp += 5;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
    if (alu_enable !== 1'b0) begin n_bad++; $display("FAIL reset_alu_enable: got %0b required 0", alu_enable); end
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL reset_fifo_count: got %0d required 0", fifo_count); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
  endtask

  // Accept at E0: enable high only after E1, rsp_valid after E3.
  task automatic test_single();
    rsp_ready = 1'b1;
    push_cmd(5'd0, 16'h0012, 16'h0034, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (alu_enable !== 1'b0) begin n_bad++; $display("FAIL lat_e0_enable: got %0b required 0", alu_enable); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL lat_e0_busy: got %0b required 1", busy); end
    @(negedge clk);
    n_cmp += 3;
    if (alu_enable !== 1'b1) begin n_bad++; $display("FAIL lat_e1_enable: got %0b required 1", alu_enable); end
    if (alu_x !== 16'h0012) begin n_bad++; $display("FAIL lat_e1_alu_x: got %h required 0012", alu_x); end
    if (alu_y !== 16'h0034) begin n_bad++; $display("FAIL lat_e1_alu_y: got %h required 0034", alu_y); end
    @(negedge clk);
    n_cmp += 2;
    if (alu_enable !== 1'b0) begin n_bad++; $display("FAIL lat_e2_enable: got %0b required 0", alu_enable); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL lat_e2_rsp_valid: got %0b required 0", rsp_valid); end
    @(negedge clk);
    n_cmp += 2;
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL lat_e3_rsp_valid: got %0b required 1", rsp_valid); end
    if (rsp_a !== 16'h0046) begin n_bad++; $display("FAIL lat_e3_rsp_a: got %h required 0046", rsp_a); end
    @(posedge clk);
    #1;
    wait_drain(20);
  endtask

  task automatic test_full();
    rsp_ready = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      push_cmd(5'(i % 5), 16'($urandom_range(0, 16'hffff)), 16'($urandom_range(0, 16'hffff)), 1'b1);
    end
    // One command is in flight, FIFO_DEPTH are queued.
    n_cmp += 2;
    if (fifo_count !== CW'(FIFO_DEPTH)) begin n_bad++; $display("FAIL full_count: got %0d required %0d", fifo_count, FIFO_DEPTH); end
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b required 0", cmd_ready); end
    // An extra command presented while full must be ignored.
    cmd_op    = 5'd4;
    cmd_x     = 16'hdead;
    cmd_y     = 16'hbeef;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_cmp += 2;
    if (fifo_count !== CW'(FIFO_DEPTH)) begin n_bad++; $display("FAIL full_ignore_count: got %0d required %0d", fifo_count, FIFO_DEPTH); end
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ignore_ready: got %0b required 0", cmd_ready); end
    rsp_ready = 1'b1;
    wait_drain(200);
  endtask

  task automatic test_stall();
    logic [23:0] held;
    rsp_ready = 1'b0;
    push_cmd(5'd3, 16'h0f00, 16'h00a5, 1'b1);
    push_cmd(5'd2, 16'hff0f, 16'h3c3c, 1'b1);
    cmd_valid = 1'b0;
    wait_rsp_valid(20);
    held = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if ({rsp_a, rsp_f} !== held) begin
        n_bad++;
        $display("FAIL stall_hold: got a=%h f=%h required a=%h f=%h", rsp_a, rsp_f, held[23:8], held[7:0]);
      end
      if (alu_enable !== 1'b0) begin n_bad++; $display("FAIL stall_enable: got %0b required 0", alu_enable); end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp += 2;
    if (alu_enable !== 1'b1) begin n_bad++; $display("FAIL stall_next_issue: got %0b required 1", alu_enable); end
    if (alu_op !== 5'd2) begin n_bad++; $display("FAIL stall_next_op: got %0d required 2", alu_op); end
    @(posedge clk);
    #1;
    wait_drain(30);
  endtask

  task automatic test_write_a();
    rsp_ready = 1'b1;
    push_cmd(5'd0, 16'h1200, 16'h0034, 1'b1);
    wait_drain(20);
    rsp_ready = 1'b0;
    push_cmd(5'd1, 16'h0005, 16'h0005, 1'b0);
    cmd_valid = 1'b0;
    wait_rsp_valid(20);
    n_cmp += 2;
    if (rsp_a !== 16'h1234) begin n_bad++; $display("FAIL write_a0_rsp_a: got %h required 1234", rsp_a); end
    // sub 5-5: zero=1, neg=0, carry=0, op=1
    if (rsp_f !== 8'h81) begin n_bad++; $display("FAIL write_a0_rsp_f: got %h required 81", rsp_f); end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_cmd(5'($urandom_range(0, 6)), 16'($urandom_range(0, 16'hffff)),
               16'($urandom_range(0, 16'hffff)), 1'($urandom_range(0, 1)));
    end
    wait_drain(100);
    // Random response back-pressure.
    for (int i = 0; i < 6; i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      push_cmd(5'($urandom_range(0, 6)), 16'($urandom_range(0, 16'hffff)),
               16'($urandom_range(0, 16'hffff)), 1'($urandom_range(0, 1)));
    end
    rsp_ready = 1'b1;
    wait_drain(100);
  endtask

  // c0 at E0, c1 at E1 (c0 popped), c2 at E2: CAPTURE with two queued.
  task automatic test_reset_mid();
    int pulses;
    rsp_ready = 1'b1;
    push_cmd(5'd0, 16'h0001, 16'h0002, 1'b1);
    push_cmd(5'd3, 16'h0010, 16'h0020, 1'b1);
    push_cmd(5'd4, 16'h00ff, 16'h0f0f, 1'b1);
    cmd_valid = 1'b0;
    n_cmp += 1;
    if (fifo_count !== CW'(2)) begin n_bad++; $display("FAIL mid_pre_count: got %0d required 2", fifo_count); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    acc_model = '0;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b required 0", busy); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL mid_count: got %0d required 0", fifo_count); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid: got %0b required 0", rsp_valid); end
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_cmd_ready: got %0b required 1", cmd_ready); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (alu_enable === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL mid_no_enable: got %0d pulses required 0", pulses); end
    @(posedge clk);
    #1;
    // The block must still work normally afterwards.
    push_cmd(5'd0, 16'h0100, 16'h0023, 1'b1);
    wait_drain(20);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_x       = '0;
    cmd_y       = '0;
    cmd_write_a = 1'b0;
    rsp_ready   = 1'b0;
    acc_model   = '0;
    test_reset();
    test_single();
    test_full();
    test_stall();
    test_write_a();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
